simple_uart: RTL

- Memory-mapped 8N1 UART peripheral on the shared CPU data bus, alongside the RAM.
- The CPU reaches it with STA_RAM/LDA to offsets 0..7 of its device slot (CR at +0, DO at +5). It uses the same device_select/we/oe decode and tri-state read-back as every other bus slave.
- Contains a 4-deep TX FIFO, a TX shifter, an RX deserialiser with a 1-byte holding register, and a programmable baud divisor.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/simple_uart_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/simple_uart.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bit indices and FSM state types for simple_uart
// Purpose: constants and types used by the UART top, FIFO and testbench.
// Ports: none (package).
package uart_pkg;

    // Register offsets, decoded from addr_in[2:0]
    localparam logic [2:0] OFF_CR     = 3'd0;
    localparam logic [2:0] OFF_SR     = 3'd1;
    localparam logic [2:0] OFF_DIV_LO = 3'd2;
    localparam logic [2:0] OFF_DIV_HI = 3'd3;
    localparam logic [2:0] OFF_DI     = 3'd4;
    localparam logic [2:0] OFF_DO     = 3'd5;

    // Status register bit indices
    localparam int SR_TX_FULL      = 0;
    localparam int SR_TX_EMPTY     = 1;
    localparam int SR_TX_BUSY      = 2;
    localparam int SR_RX_VALID     = 3;
    localparam int SR_RX_OVERRUN   = 4;
    localparam int SR_RX_FRAME_ERR = 5;
    localparam int SR_TX_OVERFLOW  = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/simple_uart_if.sv
// rtl/simple_uart_if.sv - CPU bus request signals seen by the UART slave
// Purpose: groups the shared-bus select/address/strobe/write-data signals.
// Signals: device_select[2:0], addr_in[15:0], we, oe, data_in[7:0].
// Modports: master drives the bus, slave (the UART) observes it.
interface simple_uart_if;
    logic [2:0]  device_select;
    logic [15:0] addr_in;
    logic        we;
    logic        oe;
    logic [7:0]  data_in;

    modport master (output device_select, addr_in, we, oe, data_in);
    modport slave  (input  device_select, addr_in, we, oe, data_in);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO for the UART transmit path
// Purpose: DEPTH x WIDTH FIFO, pointers carry an extra MSB to tell full from empty.
// Ports: clk, rst_n (sync active-low), i_push/i_data, i_pop, o_data (head entry),
//        o_full, o_empty. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Full/empty come from registered pointers, so a same-cycle pop never makes room
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/simple_uart.sv
// rtl/simple_uart.sv - memory-mapped 8N1 UART bus slave with TX FIFO and RX holding register
// Purpose: CR/SR/DIV/DI/DO registers on offsets 0..7, TX shifter fed by a FIFO,
//          RX deserialiser with overrun/framing detection, programmable baud divisor.
// Ports: clk, rst_n (sync active-low), bus (simple_uart_if.slave: device_select,
//        addr_in, we, oe, data_in), data_out (tri-stated unless oe && selected),
//        txd (serial out, idle high), rxd (asynchronous serial in).
module simple_uart
    import uart_pkg::*;
#(
    parameter logic [2:0]  device_address = 3'b111,
    parameter logic [15:0] DEFAULT_DIV    = 16'd103,
    parameter int          TX_DEPTH       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    simple_uart_if.slave       bus,
    output logic [7:0]         data_out,
    output logic               txd,
    input  logic               rxd
);
    logic [1:0]  r_cr;
    logic [15:0] r_div;
    logic        r_oe_q;
    logic        r_tx_overflow, r_rx_overrun, r_rx_frame_err, r_rx_valid;
    logic [7:0]  r_rx_data;

    logic        w_sel, w_wr, w_rd_di, w_pop_di, w_w1c;
    logic [2:0]  w_off;
    logic        w_unused_addr;
    logic [7:0]  w_sr, w_rdata;

    assign w_sel    = (bus.device_select == device_address);
    assign w_off    = bus.addr_in[2:0];
    assign w_wr     = bus.we && w_sel;
    assign w_w1c    = w_wr && (w_off == OFF_SR);
    assign w_rd_di  = bus.oe && w_sel && (w_off == OFF_DI);
    // Pop only on the first cycle of a DI read so a held oe pops once
    assign w_pop_di = w_rd_di && !r_oe_q;
    assign w_unused_addr = ^bus.addr_in[15:3];

    // ---------------- TX FIFO ----------------
    logic       w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty;
    logic [7:0] w_fifo_data;

    assign w_fifo_push = w_wr && (w_off == OFF_DO);

    uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fifo_push),
        .i_data  (bus.data_in),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ---------------- TX FSM ----------------
    tx_state_t   r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        w_tx_go;

    assign w_tx_go = r_cr[1] && !w_fifo_empty;

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_fifo_pop   = 1'b0;
        txd          = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_go) begin
                    w_fifo_pop   = 1'b1;
                    w_tx_shift_n = w_fifo_data;
                    w_tx_cnt_n   = r_div;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_n   = r_div;
                    w_tx_bit_n   = 3'd0;
                    w_tx_state_n = TX_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                txd = r_tx_shift[0];
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_n   = r_div;
                    w_tx_shift_n = r_tx_shift >> 1;
                    w_tx_bit_n   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_n = TX_STOP;
                end else begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end
            end
            default: begin // TX_STOP
                if (r_tx_cnt == 16'd0) begin
                    // Chain straight into the next start bit so back-to-back frames have no gap
                    if (w_tx_go) begin
                        w_fifo_pop   = 1'b1;
                        w_tx_shift_n = w_fifo_data;
                        w_tx_cnt_n   = r_div;
                        w_tx_state_n = TX_START;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end
            end
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_t   r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        r_rx_s1, r_rx_s2;
    logic        w_rx_stop_ok, w_rx_stop_bad;

    always_comb begin
        w_rx_state_n  = r_rx_state;
        w_rx_cnt_n    = r_rx_cnt;
        w_rx_bit_n    = r_rx_bit;
        w_rx_shift_n  = r_rx_shift;
        w_rx_stop_ok  = 1'b0;
        w_rx_stop_bad = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_s2) begin
                    w_rx_cnt_n   = r_div >> 1;  // resample mid start bit
                    w_rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == 16'd0) begin
                    if (r_rx_s2) begin
                        w_rx_state_n = RX_IDLE;  // glitch
                    end else begin
                        w_rx_cnt_n   = r_div;
                        w_rx_bit_n   = 3'd0;
                        w_rx_state_n = RX_DATA;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == 16'd0) begin
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_n   = r_div;
                    w_rx_bit_n   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                end else begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end
            end
            default: begin // RX_STOP
                if (r_rx_cnt == 16'd0) begin
                    w_rx_stop_ok  = r_rx_s2;
                    w_rx_stop_bad = !r_rx_s2;
                    w_rx_state_n  = RX_IDLE;
                end else begin
                    w_rx_cnt_n = r_rx_cnt - 16'd1;
                end
            end
        endcase
        // Disabling the receiver abandons any frame in progress
        if (!r_cr[0]) begin
            w_rx_state_n  = RX_IDLE;
            w_rx_stop_ok  = 1'b0;
            w_rx_stop_bad = 1'b0;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;  r_tx_cnt <= '0;  r_tx_bit <= '0;  r_tx_shift <= '0;
            r_rx_state <= RX_IDLE;  r_rx_cnt <= '0;  r_rx_bit <= '0;  r_rx_shift <= '0;
            r_rx_s1    <= 1'b1;     r_rx_s2  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;  r_tx_cnt <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;    r_tx_shift <= w_tx_shift_n;
            r_rx_state <= w_rx_state_n;  r_rx_cnt <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;    r_rx_shift <= w_rx_shift_n;
            r_rx_s1    <= rxd;           r_rx_s2  <= r_rx_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cr <= '0;  r_div <= DEFAULT_DIV;  r_oe_q <= 1'b0;
            r_tx_overflow <= 1'b0;  r_rx_overrun <= 1'b0;  r_rx_frame_err <= 1'b0;
            r_rx_valid <= 1'b0;     r_rx_data <= '0;
        end else begin
            r_oe_q <= w_rd_di;
            if (w_wr && (w_off == OFF_CR))     r_cr        <= bus.data_in[1:0];
            if (w_wr && (w_off == OFF_DIV_LO)) r_div[7:0]  <= bus.data_in;
            if (w_wr && (w_off == OFF_DIV_HI)) r_div[15:8] <= bus.data_in;
            // Sticky flags: a set event wins over a same-cycle write-1-to-clear
            r_tx_overflow  <= (r_tx_overflow  && !(w_w1c && bus.data_in[SR_TX_OVERFLOW]))
                              || (w_fifo_push && w_fifo_full);
            r_rx_overrun   <= (r_rx_overrun   && !(w_w1c && bus.data_in[SR_RX_OVERRUN]))
                              || (w_rx_stop_ok && r_rx_valid && !w_pop_di);
            r_rx_frame_err <= (r_rx_frame_err && !(w_w1c && bus.data_in[SR_RX_FRAME_ERR]))
                              || w_rx_stop_bad;
            if (w_rx_stop_ok && (!r_rx_valid || w_pop_di)) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_pop_di) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // ---------------- read-back ----------------
    always_comb begin
        w_sr                  = '0;
        w_sr[SR_TX_FULL]      = w_fifo_full;
        w_sr[SR_TX_EMPTY]     = w_fifo_empty;
        w_sr[SR_TX_BUSY]      = (r_tx_state != TX_IDLE);
        w_sr[SR_RX_VALID]     = r_rx_valid;
        w_sr[SR_RX_OVERRUN]   = r_rx_overrun;
        w_sr[SR_RX_FRAME_ERR] = r_rx_frame_err;
        w_sr[SR_TX_OVERFLOW]  = r_tx_overflow;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CR:     w_rdata = {6'd0, r_cr};
            OFF_SR:     w_rdata = w_sr;
            OFF_DIV_LO: w_rdata = r_div[7:0];
            OFF_DIV_HI: w_rdata = r_div[15:8];
            OFF_DI:     w_rdata = r_rx_data;
            default:    w_rdata = '0;
        endcase
    end

    assign data_out = (bus.oe && w_sel) ? w_rdata : 8'hzz;
endmodule
